// File: rtl/hispi_align_ctrl.sv
// Word-alignment training controller for the HiSPi deserializer lanes.
// Trains lanes in order by pulsing per-lane bitslip until the recovered word matches TRAIN_PATTERN.
//
// state   | meaning
// S_IDLE  | waiting for a rising edge on i_bitslip_en
// S_WAIT  | letting the deserializer pipeline settle after a slip or lane change
// S_CHECK | comparing the current lane word against TRAIN_PATTERN
// S_SLIP  | one-cycle bitslip pulse on the current lane
// S_NEXT  | current lane finished (locked or failed), advance or finish
// S_DONE  | training complete, status flags valid
module hispi_align_ctrl #(
   parameter int                     CHANNEL_NUM   = 4,
   parameter int                     DESER_WIDTH   = 6,
   parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = 6'b111000,
   parameter int                     MATCH_COUNT   = 16,
   parameter int                     SLIP_WAIT     = 4,
   parameter int                     MAX_SLIP      = 12
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_bitslip_en,
   input  logic [DESER_WIDTH*CHANNEL_NUM-1:0] iv_data,
   output logic [CHANNEL_NUM-1:0]             ov_bitslip,
   output logic [CHANNEL_NUM-1:0]             ov_chan_locked,
   output logic                               o_bitslip_done,
   output logic                               o_train_fail
);

   localparam int CH_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
   localparam logic [CH_W-1:0]        CH_LAST   = CH_W'(CHANNEL_NUM - 1);
   localparam logic [7:0]             MATCH_TOP = 8'(MATCH_COUNT - 1);
   localparam logic [7:0]             SLIP_MAX  = 8'(MAX_SLIP);
   localparam logic [3:0]             WAIT_LOAD = 4'(SLIP_WAIT);
   localparam logic [CHANNEL_NUM-1:0] ONE_HOT0  = CHANNEL_NUM'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_CHECK,
      S_SLIP,
      S_NEXT,
      S_DONE
   } state_t;

   state_t                           state;
   logic [DESER_WIDTH*CHANNEL_NUM-1:0] data_r;
   logic                             en_d;
   logic [CH_W-1:0]                  ch;
   logic [7:0]                       match_cnt;
   logic [7:0]                       slip_cnt;
   logic [3:0]                       wait_cnt;
   logic [DESER_WIDTH-1:0]           lane_word;
   logic                             lane_match;
   logic                             start;

   assign start = i_bitslip_en & ~en_d;

   always_comb begin
      lane_word = '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         if (ch == CH_W'(c)) lane_word = data_r[c*DESER_WIDTH +: DESER_WIDTH];
      end
      lane_match = (lane_word == TRAIN_PATTERN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         data_r         <= '0;
         en_d           <= 1'b0;
         ch             <= '0;
         match_cnt      <= '0;
         slip_cnt       <= '0;
         wait_cnt       <= '0;
         ov_bitslip     <= '0;
         ov_chan_locked <= '0;
         o_bitslip_done <= 1'b0;
         o_train_fail   <= 1'b0;
      end else begin
         data_r     <= iv_data;
         en_d       <= i_bitslip_en;
         ov_bitslip <= '0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  ov_chan_locked <= '0;
                  o_bitslip_done <= 1'b0;
                  o_train_fail   <= 1'b0;
                  ch             <= '0;
                  match_cnt      <= '0;
                  slip_cnt       <= '0;
                  wait_cnt       <= WAIT_LOAD;
                  state          <= S_WAIT;
               end
            end
            S_DONE: begin
               // Status and lock flags stay put until the next start.
               if (!i_bitslip_en) state <= S_IDLE;
            end
            default: begin
               if (!i_bitslip_en) begin
                  ov_chan_locked <= '0;
                  ch             <= '0;
                  match_cnt      <= '0;
                  slip_cnt       <= '0;
                  wait_cnt       <= '0;
                  state          <= S_IDLE;
               end else begin
                  case (state)
                     S_WAIT: begin
                        if (wait_cnt <= 4'd1) begin
                           match_cnt <= '0;
                           state     <= S_CHECK;
                        end else begin
                           wait_cnt <= wait_cnt - 4'd1;
                        end
                     end
                     S_CHECK: begin
                        if (lane_match) begin
                           if (match_cnt >= MATCH_TOP) begin
                              ov_chan_locked[ch] <= 1'b1;
                              state              <= S_NEXT;
                           end else begin
                              match_cnt <= match_cnt + 8'd1;
                           end
                        end else if (slip_cnt >= SLIP_MAX) begin
                           state <= S_NEXT;
                        end else begin
                           ov_bitslip <= ONE_HOT0 << ch;
                           state      <= S_SLIP;
                        end
                     end
                     S_SLIP: begin
                        slip_cnt <= slip_cnt + 8'd1;
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                     end
                     S_NEXT: begin
                        slip_cnt  <= '0;
                        match_cnt <= '0;
                        if (ch == CH_LAST) begin
                           o_bitslip_done <= &ov_chan_locked;
                           o_train_fail   <= ~&ov_chan_locked;
                           state          <= S_DONE;
                        end else begin
                           ch       <= ch + CH_W'(1);
                           wait_cnt <= WAIT_LOAD;
                           state    <= S_WAIT;
                        end
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hispi_align_ctrl.sv
// Bench for hispi_align_ctrl: lane model with rotation offsets and slip latency,
// expectations derived from per-lane training time and slip-count arithmetic.
module tb_hispi_align_ctrl;

   localparam int N  = 4;
   localparam int W  = 6;
   localparam int MC = 16;
   localparam int SW = 4;
   localparam int MS = 12;
   localparam logic [W-1:0] PAT = 6'b111000;

   logic           clk = 1'b0;
   logic           reset;
   logic           en;
   logic [N*W-1:0] iv_data;
   logic [N-1:0]   ov_bitslip;
   logic [N-1:0]   ov_chan_locked;
   logic           done;
   logic           fail;

   hispi_align_ctrl #(
      .CHANNEL_NUM  (N),
      .DESER_WIDTH  (W),
      .TRAIN_PATTERN(PAT),
      .MATCH_COUNT  (MC),
      .SLIP_WAIT    (SW),
      .MAX_SLIP     (MS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_bitslip_en  (en),
      .iv_data       (iv_data),
      .ov_bitslip    (ov_bitslip),
      .ov_chan_locked(ov_chan_locked),
      .o_bitslip_done(done),
      .o_train_fail  (fail)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int off[N];
   bit stuck[N];
   bit frozen[N];
   logic [W-1:0] stuck_val[N];
   int pulse_cnt[N];
   int glitch_lane = -1;
   int glitch_cyc = -1;
   logic [N-1:0] pipe1 = '0;
   logic [N-1:0] pipe2 = '0;
   logic [N-1:0] prev_slip = '0;

   function automatic logic [W-1:0] rot(input logic [W-1:0] p, input int k);
      logic [2*W-1:0] d;
      d = {p, p} >> k;
      return d[W-1:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_data();
      logic [W-1:0] w;
      for (int c = 0; c < N; c++) begin
         w = stuck[c] ? stuck_val[c] : rot(PAT, off[c]);
         if (glitch_lane == c && cyc == glitch_cyc) w = ~w;
         iv_data[c*W +: W] = w;
      end
   endtask

   // One clock: deserializer applies slips two cycles after it sees the pulse.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < N; c++)
         if (pipe2[c] && !frozen[c] && !stuck[c]) off[c] = (off[c] + W - 1) % W;
      pipe2 = pipe1;
      pipe1 = ov_bitslip;
      for (int c = 0; c < N; c++) if (ov_bitslip[c]) pulse_cnt[c]++;
      check("slip_onehot", 32'($onehot0(ov_bitslip)), 32'd1);
      check("slip_back_to_back", 32'(ov_bitslip & prev_slip), 32'd0);
      prev_slip = ov_bitslip;
      drive_data();
   endtask

   task automatic run_training(input string tag, input int extra_t0, input int extra_p0,
                               input int glitch_rel);
      int lane_t[N];
      int exp_lock_t[N];
      int exp_p[N];
      int got_lock_t[N];
      logic [N-1:0] exp_lock;
      int cum;
      int k;
      exp_lock = '0;
      cum = 0;
      for (int c = 0; c < N; c++) begin
         if (stuck[c]) begin
            lane_t[c] = SW + MS * (2 + SW) + 1;
            exp_p[c]  = MS;
         end else begin
            lane_t[c]   = SW + off[c] * (2 + SW) + MC;
            exp_p[c]    = off[c];
            exp_lock[c] = 1'b1;
         end
      end
      lane_t[0] += extra_t0;
      exp_p[0]  += extra_p0;
      for (int c = 0; c < N; c++) begin
         cum += lane_t[c];
         exp_lock_t[c] = exp_lock[c] ? cum : -1;
         cum += 1;
      end
      for (int c = 0; c < N; c++) begin
         pulse_cnt[c]  = 0;
         got_lock_t[c] = -1;
      end
      if (glitch_rel >= 0) begin
         glitch_lane = 0;
         glitch_cyc  = cyc + 1 + glitch_rel;
      end
      en = 1'b1;
      step();
      t0 = cyc;
      k = 0;
      while (!(done || fail) && k < 1000) begin
         step();
         k++;
         for (int c = 0; c < N; c++)
            if (ov_chan_locked[c] && got_lock_t[c] < 0) got_lock_t[c] = cyc - t0;
      end
      glitch_lane = -1;
      check({tag, "_done_time"}, 32'(cyc - t0), 32'(cum));
      check({tag, "_locked"}, 32'(ov_chan_locked), 32'(exp_lock));
      check({tag, "_done"}, 32'(done), 32'(&exp_lock));
      check({tag, "_fail"}, 32'(fail), 32'(~&exp_lock));
      for (int c = 0; c < N; c++) begin
         check($sformatf("%s_pulses_lane%0d", tag, c), 32'(pulse_cnt[c]), 32'(exp_p[c]));
         check($sformatf("%s_lock_time_lane%0d", tag, c), 32'(got_lock_t[c]), 32'(exp_lock_t[c]));
      end
      repeat (3) step();
      check({tag, "_done_hold"}, 32'({done, fail}), 32'({&exp_lock, ~&exp_lock}));
      en = 1'b0;
      repeat (2) step();
      check({tag, "_idle_flags_held"}, 32'({done, fail}), 32'({&exp_lock, ~&exp_lock}));
      check({tag, "_idle_locked_held"}, 32'(ov_chan_locked), 32'(exp_lock));
   endtask

   initial begin
      reset   = 1'b1;
      en      = 1'b0;
      iv_data = '0;
      for (int c = 0; c < N; c++) begin
         off[c] = 0; stuck[c] = 1'b0; frozen[c] = 1'b0; stuck_val[c] = '0; pulse_cnt[c] = 0;
      end
      drive_data();
      repeat (3) @(negedge clk);
      check("reset_bitslip", 32'(ov_bitslip), 32'd0);
      check("reset_locked", 32'(ov_chan_locked), 32'd0);
      check("reset_flags", 32'({done, fail}), 32'd0);
      reset = 1'b0;
      repeat (5) step();
      check("idle_no_start_locked", 32'(ov_chan_locked), 32'd0);
      check("idle_no_start_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);

      run_training("aligned", 0, 0, -1);

      off[2] = 3;
      run_training("lane2_off3", 0, 0, -1);

      stuck[1] = 1'b1;
      stuck_val[1] = 6'b000000;
      run_training("lane1_stuck", 0, 0, -1);
      stuck[1] = 1'b0;

      // Lane 0 matches 15 words, the 16th is corrupted: one slip, then 16 fresh matches.
      for (int c = 0; c < N; c++) off[c] = 0;
      frozen[0] = 1'b1;
      run_training("intermittent", (MC - 1) + 2 + SW, 1, SW + MC - 2);
      frozen[0] = 1'b0;

      // Abort during lane 1 settle time.
      for (int c = 0; c < N; c++) begin off[c] = 0; pulse_cnt[c] = 0; end
      en = 1'b1;
      step();
      t0 = cyc;
      while (cyc - t0 < SW + MC + 2) step();
      check("abort_pre_locked", 32'(ov_chan_locked), 32'b0001);
      en = 1'b0;
      step();
      check("abort_locked", 32'(ov_chan_locked), 32'd0);
      check("abort_bitslip", 32'(ov_bitslip), 32'd0);
      check("abort_flags", 32'({done, fail}), 32'd0);
      repeat (6) step();
      check("abort_quiet_locked", 32'(ov_chan_locked), 32'd0);
      run_training("restart", 0, 0, -1);

      // Asynchronous reset in the middle of lane 2 compare.
      en = 1'b1;
      step();
      t0 = cyc;
      while (cyc - t0 < 50) step();
      check("prereset_locked", 32'(ov_chan_locked), 32'b0011);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_locked", 32'(ov_chan_locked), 32'd0);
      check("async_reset_bitslip", 32'(ov_bitslip), 32'd0);
      check("async_reset_flags", 32'({done, fail}), 32'd0);
      en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < N; c++) pulse_cnt[c] = 0;
      repeat (10) step();
      check("post_reset_quiet_locked", 32'(ov_chan_locked), 32'd0);
      check("post_reset_quiet_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);
      check("post_reset_quiet_flags", 32'({done, fail}), 32'd0);
      run_training("post_reset", 0, 0, -1);

      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < N; c++) begin
            off[c]   = int'($urandom_range(0, W - 1));
            stuck[c] = ($urandom_range(0, 4) == 0);
            stuck_val[c] = 6'($urandom_range(0, 63));
            if (stuck_val[c] == PAT) stuck_val[c] = 6'b010101;
         end
         run_training($sformatf("random%0d", i), 0, 0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hispi_align_ctrl.md
Name: hispi_align_ctrl

Overview:
Word-alignment training controller that sequences the per-channel bitslip of the source-synchronous deserializer ahead of the HiSPi decoder. On request it trains channels 0..CHANNEL_NUM-1 one at a time. For each channel it compares the recovered parallel word against a training pattern and pulses that channel's bitslip until the match is stable, then reports lock, done and failure status. It runs in the clk_recover domain, between the deserializer's ov_data_recover output and its iv_bitslip input.

Parameters:
CHANNEL_NUM, 4, number of serial data lanes
DESER_WIDTH, 6, deserialization ratio (bits per lane word)
TRAIN_PATTERN, 6'b111000, expected aligned word, DESER_WIDTH bits
MATCH_COUNT, 16, consecutive matching words required for lock (range 1..255)
SLIP_WAIT, 4, idle cycles after a bitslip pulse before comparing again (deserializer slip latency, range 1..15)
MAX_SLIP, 12, bitslip pulses allowed per channel before it is declared failed

Ports:
clk  input  1  recovered parallel clock (clk_recover)
reset  input  1  asynchronous, active-high reset (reset_recover)
i_bitslip_en  input  1  training enable; rising edge starts training, low aborts or clears
iv_data  input  DESER_WIDTH*CHANNEL_NUM  deserialized words; lane c = iv_data[c*DESER_WIDTH +: DESER_WIDTH]
ov_bitslip  output  CHANNEL_NUM  one-cycle bitslip pulse, one-hot, to deserializer iv_bitslip
ov_chan_locked  output  CHANNEL_NUM  per-lane lock flag
o_bitslip_done  output  1  training finished with every lane locked
o_train_fail  output  1  training finished with at least one lane failed

Behaviour:
- Reset (async assert, release synchronous to clk):
  - all outputs 0; state IDLE; channel index ch=0; match_cnt=0; slip_cnt=0; wait_cnt=0; en_d=0.
- Input registration:
  - iv_data registered once (data_r); all compares use data_r[ch*DESER_WIDTH +: DESER_WIDTH].
  - i_bitslip_en registered into en_d; start = i_bitslip_en & ~en_d.
- IDLE:
  - on start: clear ov_chan_locked, o_bitslip_done, o_train_fail; ch=0; go WAIT with wait_cnt=SLIP_WAIT so the pipeline settles.
- WAIT:
  - wait_cnt decrements each cycle; at 1, go CHECK with match_cnt=0.
- CHECK (each cycle):
  - lane word == TRAIN_PATTERN: match_cnt++. When match_cnt reaches MATCH_COUNT-1 on a match, set ov_chan_locked[ch] and go NEXT.
  - mismatch: if slip_cnt == MAX_SLIP, go NEXT with lane unlocked (failed); else go SLIP.
- SLIP:
  - lasts exactly one cycle; ov_bitslip[ch]=1 in that cycle only; slip_cnt++; go WAIT with wait_cnt=SLIP_WAIT.
  - latency: data_r mismatch in cycle n produces the pulse in cycle n+1.
- NEXT:
  - slip_cnt=0; match_cnt=0.
  - if ch==CHANNEL_NUM-1, go DONE; else ch++ and go WAIT with wait_cnt=SLIP_WAIT.
- DONE:
  - o_bitslip_done = &ov_chan_locked; o_train_fail = ~&ov_chan_locked.
  - both registered, valid from the first DONE cycle, held while i_bitslip_en=1.
  - when i_bitslip_en=0, go IDLE; flags and ov_chan_locked are held until the next start.
- Abort:
  - i_bitslip_en=0 in any state except IDLE/DONE: go IDLE next cycle; ov_bitslip forced 0; ov_chan_locked cleared; done/fail stay 0.
  - a slip pulse in progress still completes its single cycle only if it was already registered.
- Simultaneous start and abort are impossible (same signal). Start is ignored outside IDLE; re-training requires a low then high on i_bitslip_en.
- Counters:
  - match_cnt is 8 bits, slip_cnt is 8 bits, wait_cnt is 4 bits; none wraps (saturating compares above).
- Invariants:
  - ov_bitslip is never more than one-hot and never high two consecutive cycles.
  - ov_chan_locked bits are only set for ch ≤ current index.

Test Plan:
- Aligned lanes: CHANNEL_NUM=4, all lanes already 6'b111000 → no ov_bitslip pulses; ov_chan_locked=4'b1111 and o_bitslip_done=1 after 4×(4+16)+5 ≈ 85 cycles from start; o_train_fail=0.
- Lane 2 offset by 3 bits (bench model rotates one bit per slip after 2 cycles) → exactly 3 pulses on ov_bitslip[2], each followed by ≥4 quiet cycles; final ov_chan_locked=4'b1111, done=1.
- Lane 1 stuck at 6'b000000 → 12 pulses on ov_bitslip[1], then lanes 2 and 3 trained; ov_chan_locked=4'b1101, o_train_fail=1, o_bitslip_done=0.
- Intermittent match: lane 0 matches 15 cycles, then 1 mismatch → exactly one slip pulse, match_cnt restarts, lock only after 16 fresh consecutive matches.
- Abort: drop i_bitslip_en during lane 1 SLIP_WAIT → IDLE next cycle, all outputs 0; re-raise → training restarts at lane 0.
- Async reset asserted mid-CHECK (not on a clk edge) → all outputs 0 immediately; after release, no activity until a new rising edge of i_bitslip_en.
